// File: rtl/mem2mem_pkg.sv
// Shared constants, field positions and FSM encoding for the BRAM-to-BRAM copy sequencer.
package mem2mem_pkg;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned WEN_W = 4;
    localparam int unsigned CNT_W = AW + 1;

    localparam int unsigned CFG_START_BIT = 31;
    localparam int unsigned CFG_ABORT_BIT = 30;
    localparam int unsigned CFG_LEN_LSB   = 20;
    localparam int unsigned CFG_SRC_LSB   = 10;
    localparam int unsigned CFG_DST_LSB   = 0;

    localparam int unsigned ST_BUSY_BIT    = 31;
    localparam int unsigned ST_DONE_BIT    = 30;
    localparam int unsigned ST_ABORTED_BIT = 29;
    localparam int unsigned ST_CNT_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Word address inside a 4 KB buffer to a 32-bit byte address.
    function automatic logic [DW-1:0] byte_addr(input logic [AW-1:0] word);
        return DW'({word, 2'b00});
    endfunction

endpackage

// File: rtl/bram_copy_ctrl_if.sv
// Port-B pin groups of the RX (BRAM1) and TX (BRAM0) buffers owned by the copy sequencer.
interface bram_copy_ctrl_if;
    import mem2mem_pkg::*;

    logic             rx_en;
    logic [WEN_W-1:0] rx_wen;
    logic [DW-1:0]    rx_addr;
    logic [DW-1:0]    rx_rdata;
    logic             tx_en;
    logic [WEN_W-1:0] tx_wen;
    logic [DW-1:0]    tx_addr;
    logic [DW-1:0]    tx_wdata;

    modport master (
        output rx_en, rx_wen, rx_addr,
        input  rx_rdata,
        output tx_en, tx_wen, tx_addr, tx_wdata
    );

    modport slave (
        input  rx_en, rx_wen, rx_addr,
        output rx_rdata,
        input  tx_en, tx_wen, tx_addr, tx_wdata
    );

endinterface

// File: rtl/bram_copy_ctrl.sv
// Copies len_m1+1 words from BRAM1 to BRAM0 at one word per clock, driven by the RXTX GPIO.
// A single FSM issues reads; a one-stage pipe turns each returned word into a write.
module bram_copy_ctrl
    import mem2mem_pkg::*;
(
    input  logic             fpga_0_clk_1_sys_clk_pin,
    input  logic             fpga_0_rst_1_sys_rst_pin,
    input  logic [DW-1:0]    cfg_word,
    output logic [DW-1:0]    status_word,
    bram_copy_ctrl_if.master bram
);

    logic clk;
    logic rst;
    assign clk = fpga_0_clk_1_sys_clk_pin;
    assign rst = fpga_0_rst_1_sys_rst_pin;

    state_e           state_q;
    logic             start_q;
    logic             abort_pend_q;
    logic             rd_vld_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic [AW-1:0]    len_q;
    logic [AW-1:0]    src_q;
    logic [AW-1:0]    dst_q;
    logic [AW-1:0]    rd_idx_q;
    logic [AW-1:0]    wr_idx_q;
    logic [CNT_W-1:0] cnt_q;

    logic          start_edge;
    logic          abort_req;
    logic          last_rd;
    logic          rd_fire;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    assign start_edge = cfg_word[CFG_START_BIT] & ~start_q;
    assign abort_req  = cfg_word[CFG_ABORT_BIT];
    assign last_rd    = (rd_idx_q == len_q);
    // The final read is never suppressed, so an abort on that cycle still ends as done.
    assign rd_fire    = (state_q == ST_READ) & (~abort_req | last_rd);
    assign rd_addr    = src_q + rd_idx_q;
    assign wr_addr    = dst_q + wr_idx_q;

    assign bram.rx_en    = rd_fire;
    assign bram.rx_wen   = '0;
    assign bram.rx_addr  = rd_fire ? byte_addr(rd_addr) : '0;
    assign bram.tx_en    = rd_vld_q;
    assign bram.tx_wen   = rd_vld_q ? {WEN_W{1'b1}} : '0;
    assign bram.tx_addr  = rd_vld_q ? byte_addr(wr_addr) : '0;
    assign bram.tx_wdata = rd_vld_q ? bram.rx_rdata : '0;

    always_comb begin
        status_word                          = '0;
        status_word[ST_BUSY_BIT]             = busy_q;
        status_word[ST_DONE_BIT]             = done_q;
        status_word[ST_ABORTED_BIT]          = aborted_q;
        status_word[ST_CNT_LSB +: CNT_W]     = cnt_q;
    end

    // start_q resets high so a start bit already set when reset drops is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b1;
            abort_pend_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            len_q        <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            rd_idx_q     <= '0;
            wr_idx_q     <= '0;
            cnt_q        <= '0;
        end else begin
            start_q  <= cfg_word[CFG_START_BIT];
            rd_vld_q <= rd_fire;

            if (rd_fire) begin
                rd_idx_q <= rd_idx_q + AW'(1);
            end
            if (rd_vld_q) begin
                wr_idx_q <= wr_idx_q + AW'(1);
                cnt_q    <= cnt_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_edge && !abort_req) begin
                        len_q        <= cfg_word[CFG_LEN_LSB +: AW];
                        src_q        <= cfg_word[CFG_SRC_LSB +: AW];
                        dst_q        <= cfg_word[CFG_DST_LSB +: AW];
                        rd_idx_q     <= '0;
                        wr_idx_q     <= '0;
                        cnt_q        <= '0;
                        done_q       <= 1'b0;
                        aborted_q    <= 1'b0;
                        abort_pend_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!rd_fire) begin
                        abort_pend_q <= 1'b1;
                        state_q      <= ST_DRAIN;
                    end else if (last_rd) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    busy_q    <= 1'b0;
                    done_q    <= ~abort_pend_q;
                    aborted_q <= abort_pend_q;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_copy_ctrl.sv
// Self-checking bench for bram_copy_ctrl: behavioural BRAMs, a copy-level reference model,
// a table of directed and random copies, and hand-written reset/start corner sequences.
module tb_bram_copy_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] cfg;
    logic [31:0] status;

    bram_copy_ctrl_if bus();

    bram_copy_ctrl dut (
        .fpga_0_clk_1_sys_clk_pin (clk),
        .fpga_0_rst_1_sys_rst_pin (rst),
        .cfg_word                 (cfg),
        .status_word              (status),
        .bram                     (bus)
    );

    logic [31:0] bram0 [1024];
    logic [31:0] bram1 [1024];

    int n_cmp;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM port B models: registered read on BRAM1, full-word write on BRAM0.
    always @(posedge clk) begin
        if (bus.rx_en) bus.rx_rdata <= bram1[bus.rx_addr[11:2]];
        if (bus.tx_en && bus.tx_wen == 4'hF) bram0[bus.tx_addr[11:2]] <= bus.tx_wdata;
    end

    typedef struct {
        int unsigned src;
        int unsigned dst;
        int unsigned len_m1;
        int unsigned abort_at;
        int unsigned glitch;
        bit          exp_done;
        bit          exp_ab;
        int unsigned exp_cnt;
        int unsigned exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_cfg(input bit st, input bit ab, input int unsigned len,
                                           input int unsigned src, input int unsigned dst);
        logic [31:0] w;
        w        = 32'h0;
        w[31]    = st;
        w[30]    = ab;
        w[29:20] = 10'(len);
        w[19:10] = 10'(src);
        w[9:0]   = 10'(dst);
        return w;
    endfunction

    // Copy outcome from the rules: an abort before the last read stops after abort_at-1 words.
    function automatic void model(input int unsigned len_m1, input int unsigned abort_at,
                                  output int unsigned n, output bit ab);
        int unsigned l;
        l  = len_m1 + 1;
        ab = (abort_at != 0) && (abort_at < l);
        n  = ab ? abort_at - 1 : l;
    endfunction

    task automatic run_copy(input int idx, input vec_t v);
        logic [31:0] snap [1024];
        logic [31:0] exp_st;
        logic [31:0] exp_w;
        int c, r, w, busy_n, rd_err, wr_err, late_rd, mem_err;
        int unsigned off;
        bit to;
        c = 0; r = 0; w = 0; busy_n = 0; rd_err = 0; wr_err = 0; late_rd = 0; mem_err = 0; to = 0;
        cfg = 32'h0;
        @(posedge clk); #1;
        for (int i = 0; i < 1024; i++) snap[i] = bram0[i];
        cfg = mk_cfg(1'b1, 1'b0, v.len_m1, v.src, v.dst);
        while (1) begin
            @(posedge clk); #1;
            c++;
            if (v.abort_at != 0 && c == v.abort_at) cfg[30] = 1'b1;
            if (v.glitch != 0 && c == v.glitch) cfg[31] = 1'b0;
            if (v.glitch != 0 && c == v.glitch + 1)
                cfg = mk_cfg(1'b1, 1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                             $urandom_range(0, 1023));
            #1;
            if (bus.rx_en) begin
                if (bus.rx_addr != 32'(((v.src + r) % 1024) * 4) || c != r + 1) rd_err++;
                if (v.exp_ab && c >= v.abort_at) late_rd++;
                r++;
            end
            if (bus.tx_en) begin
                if (bus.tx_addr != 32'(((v.dst + w) % 1024) * 4) || bus.tx_wen != 4'hF ||
                    bus.tx_wdata != bram1[(v.src + w) % 1024] || c != w + 2) wr_err++;
                w++;
            end
            if (status[31]) busy_n++;
            else if (c > 1) break;
            if (c > 1200) begin
                to = 1'b1;
                break;
            end
        end
        for (int i = 0; i < 1024; i++) begin
            off   = (32'(i) + 1024 - v.dst) % 1024;
            exp_w = (off < v.exp_cnt) ? bram1[(v.src + off) % 1024] : snap[i];
            if (bram0[i] !== exp_w) mem_err++;
        end
        exp_st = {1'b0, v.exp_done, v.exp_ab, 18'h0, 11'(v.exp_cnt)};
        check($sformatf("v%0d_timeout", idx), to, 0);
        check($sformatf("v%0d_reads", idx), r, v.exp_cnt);
        check($sformatf("v%0d_writes", idx), w, v.exp_cnt);
        check($sformatf("v%0d_rd_seq", idx), rd_err, 0);
        check($sformatf("v%0d_wr_seq", idx), wr_err, 0);
        check($sformatf("v%0d_rd_after_abort", idx), late_rd, 0);
        check($sformatf("v%0d_busy_cycles", idx), busy_n, v.exp_busy);
        check($sformatf("v%0d_status", idx), status, exp_st);
        check($sformatf("v%0d_bram0", idx), mem_err, 0);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] st_save;
        int          hits;
        int unsigned n;
        bit          ab;
        n_cmp  = 0;
        n_fail = 0;

        //                 src   dst  len  abt  gl  done ab  cnt   busy
        vecs.push_back('{    0,  100,  15,   0,  0, 1'b1,1'b0,  16,   17});
        vecs.push_back('{ 1020, 1022,   7,   0,  0, 1'b1,1'b0,   8,    9});
        vecs.push_back('{    0,    0,1023,   0,  0, 1'b1,1'b0,1024, 1025});
        vecs.push_back('{    5,  200,  99,  10,  0, 1'b0,1'b1,   9,   11});
        vecs.push_back('{   50,   60,   7,   8,  0, 1'b1,1'b0,   8,    9});
        vecs.push_back('{    0,    0,  15,   1,  0, 1'b0,1'b1,   0,    2});
        vecs.push_back('{    7,    9,   0,   0,  0, 1'b1,1'b0,   1,    2});
        vecs.push_back('{  400,   10,  31,   0,  6, 1'b1,1'b0,  32,   33});

        for (int i = 0; i < 1024; i++) bram1[i] = 32'hA000_0000 + 32'(i);

        // Start held high through reset must not trigger a copy.
        rst = 1'b1;
        cfg = mk_cfg(1'b1, 1'b0, 5, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("reset_status", status, 0);
        check("reset_rx", {bus.rx_en, bus.rx_wen, bus.rx_addr}, 0);
        check("reset_tx", {bus.tx_en, bus.tx_wen, bus.tx_addr}, 0);
        check("reset_txdata", bus.tx_wdata, 0);
        rst  = 1'b0;
        hits = 0;
        repeat (6) begin
            @(posedge clk); #2;
            if (bus.rx_en || status[31]) hits++;
        end
        check("held_start_no_copy", hits, 0);

        for (int i = 0; i < vecs.size(); i++) run_copy(i, vecs[i]);

        // Start and abort together in IDLE: no copy, status unchanged.
        cfg = 32'h0;
        @(posedge clk); #2;
        st_save = status;
        cfg     = mk_cfg(1'b1, 1'b1, 20, 3, 3);
        hits    = 0;
        repeat (4) begin
            @(posedge clk); #2;
            if (bus.rx_en) hits++;
        end
        check("start_abort_reads", hits, 0);
        check("start_abort_status", status, st_save);
        check("start_abort_sticky", status, 32'h4000_0000 | 32'h20);

        // Randomized copies checked against the model.
        for (int i = 0; i < 1024; i++) bram1[i] = $urandom;
        for (int i = 0; i < 6; i++) begin
            v.src      = $urandom_range(0, 1023);
            v.dst      = $urandom_range(0, 1023);
            v.len_m1   = $urandom_range(0, 150);
            v.abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, v.len_m1 + 2) : 0;
            v.glitch   = 0;
            model(v.len_m1, v.abort_at, n, ab);
            v.exp_cnt  = n;
            v.exp_ab   = ab;
            v.exp_done = !ab;
            v.exp_busy = ab ? n + 2 : n + 1;
            run_copy(100 + i, v);
        end

        // Reset in cycle 5 of a 64-word copy, then a fresh copy.
        cfg = 32'h0;
        @(posedge clk); #1;
        cfg = mk_cfg(1'b1, 1'b0, 63, 0, 300);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_status", status, 0);
        check("midrst_pins", {bus.rx_en, bus.rx_wen, bus.rx_addr, bus.tx_en, bus.tx_wen,
                              bus.tx_addr, bus.tx_wdata}, 0);
        cfg = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_copy(200, '{0, 300, 63, 0, 0, 1'b1, 1'b0, 64, 65});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
